// File: rtl/d_cache_ctrl.sv
// d_cache_ctrl: front-end for the rv32i data cache.
// Runs a boot-time word preload, then round-robin arbitrates single-word
// core/debug accesses, one per cycle. Read data and range errors come back
// registered, one cycle after the grant.
module d_cache_ctrl #(
    parameter int DPW   = 32,
    parameter int Depth = 120,
    parameter int LenW  = 16
) (
    input  logic            clk,
    input  logic            arst_ni,
    // preload stream
    input  logic            pl_start,
    input  logic [DPW-1:0]  pl_base,
    input  logic [LenW-1:0] pl_len,
    input  logic            pl_valid,
    input  logic [DPW-1:0]  pl_data,
    output logic            pl_ready,
    output logic            pl_busy,
    output logic            pl_done,
    // core LSU
    input  logic            core_req,
    input  logic            core_we,
    input  logic [DPW-1:0]  core_addr,
    input  logic [DPW-1:0]  core_wd,
    output logic            core_gnt,
    output logic            core_rvalid,
    output logic [DPW-1:0]  core_rdata,
    // debug master
    input  logic            dbg_req,
    input  logic            dbg_we,
    input  logic [DPW-1:0]  dbg_addr,
    input  logic [DPW-1:0]  dbg_wd,
    output logic            dbg_gnt,
    output logic            dbg_rvalid,
    output logic [DPW-1:0]  dbg_rdata,
    output logic            err,
    // d_cache side
    output logic [DPW-1:0]  c_addr,
    output logic [DPW-1:0]  c_wd,
    output logic [DPW-1:0]  c_we,
    output logic            c_data_en,
    output logic [DPW-1:0]  c_input_addr,
    output logic [DPW-1:0]  c_input_data,
    input  logic [DPW-1:0]  c_rd
);

    // DONE is a one-cycle tail after PRELOAD: pl_done is high there and no
    // grants are issued, so a pending request wins the cycle after pl_done.
    typedef enum logic [1:0] {IDLE, PRELOAD, DONE} state_t;

    state_t          state_q, state_d;
    logic [DPW-1:0]  pl_addr_q, pl_addr_d;
    logic [LenW-1:0] pl_rem_q, pl_rem_d;
    logic            last_dbg_q;
    logic            pl_abort;

    // Whole word must fit: addr+3 < Depth, widened by one bit so it cannot wrap.
    function automatic logic in_range(input logic [DPW-1:0] a);
        return ({1'b0, a} + (DPW+1)'(3)) < (DPW+1)'(Depth);
    endfunction

    assign pl_busy = (state_q == PRELOAD);
    assign pl_done = (state_q == DONE);

    // Next state, arbitration and cache port drive.
    always_comb begin
        state_d      = state_q;
        pl_addr_d    = pl_addr_q;
        pl_rem_d     = pl_rem_q;
        pl_ready     = 1'b0;
        pl_abort     = 1'b0;
        core_gnt     = 1'b0;
        dbg_gnt      = 1'b0;
        c_addr       = '0;
        c_wd         = '0;
        c_we         = '0;
        c_data_en    = 1'b0;
        c_input_addr = '0;
        c_input_data = '0;
        case (state_q)
            IDLE: begin
                // Core wins a tie unless it was the last one served.
                if (core_req && (!dbg_req || last_dbg_q)) core_gnt = 1'b1;
                else if (dbg_req)                          dbg_gnt  = 1'b1;
                if (core_gnt) begin
                    c_addr = core_addr;
                    if (core_we && in_range(core_addr)) begin
                        c_wd = core_wd;
                        c_we = '1;
                    end
                end else if (dbg_gnt) begin
                    c_addr = dbg_addr;
                    if (dbg_we && in_range(dbg_addr)) begin
                        c_wd = dbg_wd;
                        c_we = '1;
                    end
                end
                if (pl_start) begin
                    state_d   = PRELOAD;
                    pl_addr_d = pl_base;
                    pl_rem_d  = pl_len;
                end
            end
            PRELOAD: begin
                if (pl_rem_q == '0) begin
                    state_d = DONE;
                end else if (!in_range(pl_addr_q)) begin
                    // Word would fall off the end: drop the rest of the image.
                    pl_abort = 1'b1;
                    state_d  = DONE;
                end else begin
                    pl_ready = 1'b1;
                    if (pl_valid) begin
                        c_data_en    = 1'b1;
                        c_input_addr = pl_addr_q;
                        c_input_data = pl_data;
                        pl_addr_d    = pl_addr_q + DPW'(4);
                        pl_rem_d     = pl_rem_q - LenW'(1);
                        if (pl_rem_q == LenW'(1)) state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, preload cursor, RR pointer and registered responses.
    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q     <= IDLE;
            pl_addr_q   <= '0;
            pl_rem_q    <= '0;
            last_dbg_q  <= 1'b1;
            core_rvalid <= 1'b0;
            dbg_rvalid  <= 1'b0;
            core_rdata  <= '0;
            dbg_rdata   <= '0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            pl_addr_q   <= pl_addr_d;
            pl_rem_q    <= pl_rem_d;
            if (core_gnt || dbg_gnt) last_dbg_q <= dbg_gnt;
            core_rvalid <= core_gnt;
            dbg_rvalid  <= dbg_gnt;
            core_rdata  <= (core_gnt && !core_we && in_range(core_addr)) ? c_rd : '0;
            dbg_rdata   <= (dbg_gnt && !dbg_we && in_range(dbg_addr)) ? c_rd : '0;
            err         <= ((core_gnt || dbg_gnt) && !in_range(c_addr)) || pl_abort;
        end
    end

endmodule

// File: tb/tb_d_cache_ctrl.sv
// Bench for d_cache_ctrl: directed scenarios followed by random core/debug
// traffic, checked against a byte-array memory image and round-robin rules.
module tb_d_cache_ctrl;
    localparam int DEPTH = 120;

    logic        clk, arst_ni;
    logic        pl_start, pl_valid, pl_ready, pl_busy, pl_done;
    logic [31:0] pl_base, pl_data;
    logic [15:0] pl_len;
    logic        core_req, core_we, core_gnt, core_rvalid;
    logic [31:0] core_addr, core_wd, core_rdata;
    logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_addr, dbg_wd, dbg_rdata;
    logic        err, c_data_en;
    logic [31:0] c_addr, c_wd, c_we, c_input_addr, c_input_data, c_rd;

    int checks = 0;
    int failures = 0;

    // mem: the cache as the DUT drives it; ref_mem: what the bench expects.
    logic [7:0] mem     [0:DEPTH-1] = '{default: 8'h00};
    logic [7:0] ref_mem [0:DEPTH-1] = '{default: 8'h00};

    d_cache_ctrl #(.DPW(32), .Depth(DEPTH), .LenW(16)) dut (
        .clk(clk), .arst_ni(arst_ni),
        .pl_start(pl_start), .pl_base(pl_base), .pl_len(pl_len),
        .pl_valid(pl_valid), .pl_data(pl_data), .pl_ready(pl_ready),
        .pl_busy(pl_busy), .pl_done(pl_done),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wd(core_wd), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wd(dbg_wd), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata), .err(err),
        .c_addr(c_addr), .c_wd(c_wd), .c_we(c_we), .c_data_en(c_data_en),
        .c_input_addr(c_input_addr), .c_input_data(c_input_data), .c_rd(c_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit inr(input logic [31:0] a);
        return (longint'(a) + 3) < DEPTH;
    endfunction

    function automatic logic [31:0] memw(input logic [31:0] a);
        int i;
        i = int'(a);
        if (!inr(a)) return '0;
        return {mem[i+3], mem[i+2], mem[i+1], mem[i]};
    endfunction

    function automatic logic [31:0] refw(input logic [31:0] a);
        int i;
        i = int'(a);
        if (!inr(a)) return '0;
        return {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < 4; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
    endtask

    // Cache model: rd combinational from addr, writes on the clock edge.
    always_comb c_rd = memw(c_addr);

    always @(posedge clk) begin
        if (c_we != '0 && inr(c_addr))
            for (int i = 0; i < 4; i++)
                mem[int'(c_addr) + i] <= (mem[int'(c_addr) + i] & ~c_we[8*i +: 8]) |
                                         (c_wd[8*i +: 8] & c_we[8*i +: 8]);
        if (c_data_en && inr(c_input_addr))
            for (int i = 0; i < 4; i++)
                mem[int'(c_input_addr) + i] <= c_input_data[8*i +: 8];
    end

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ctl_vec();
        return 32'({pl_ready, pl_busy, pl_done, core_gnt, core_rvalid,
                    dbg_gnt, dbg_rvalid, err, c_data_en});
    endfunction

    // One access from core (dbg=0) or debug port with no competing request.
    task automatic access(input bit dbg, input bit we, input logic [31:0] a,
                          input logic [31:0] wd);
        bit          ok;
        logic [31:0] exp_rd;
        ok     = inr(a);
        exp_rd = (!we && ok) ? refw(a) : 32'h0;
        if (dbg) begin dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wd = wd; end
        else begin core_req = 1; core_we = we; core_addr = a; core_wd = wd; end
        #1;
        chk("acc_gnt", dbg ? dbg_gnt : core_gnt, 1);
        chk("acc_c_we", c_we, (we && ok) ? 32'hFFFF_FFFF : 32'h0);
        if (we && ok) ref_write(a, wd);
        tick();
        core_req = 0;
        dbg_req  = 0;
        chk("acc_rvalid", dbg ? dbg_rvalid : core_rvalid, 1);
        chk("acc_rdata", dbg ? dbg_rdata : core_rdata, exp_rd);
        chk("acc_err", 32'(err), 32'(!ok));
    endtask

    typedef struct {
        bit          vld;
        bit          we;
        logic [31:0] a;
        logic [31:0] wd;
    } req_t;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t        pc, pd;
        bit          last_dbg, gc, gd, e_err;
        logic [31:0] e_crd, e_drd;
        int          words, cyc, diffs;

        arst_ni = 0; pl_start = 0; pl_base = 0; pl_len = 0; pl_valid = 0; pl_data = 0;
        core_req = 0; core_we = 0; core_addr = 0; core_wd = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wd = 0;
        #3;
        chk("rst_ctl", ctl_vec(), 0);
        chk("rst_rdata", core_rdata | dbg_rdata, 0);
        chk("rst_c_we", c_we, 0);
        tick(); tick();
        arst_ni = 1;

        // 1: reset in the middle of a 3-word preload
        pl_start = 1; pl_base = 0; pl_len = 3;
        tick();
        pl_start = 0; pl_valid = 1; pl_data = 32'h05;
        #1;
        chk("t1_busy", pl_busy, 1);
        chk("t1_ready", pl_ready, 1);
        chk("t1_den0", c_data_en, 1);
        chk("t1_iaddr0", c_input_addr, 0);
        tick();
        pl_data = 32'h06;
        #1;
        chk("t1_iaddr1", c_input_addr, 4);
        chk("t1_idata1", c_input_data, 32'h06);
        tick();
        pl_data = 32'h07;
        arst_ni = 0;
        #1;
        chk("t1_rst_ctl", ctl_vec(), 0);
        tick();
        pl_valid = 0;
        ref_write(0, 32'h05);
        ref_write(4, 32'h06);
        chk("t1_w0", memw(0), refw(0));
        chk("t1_w4", memw(4), refw(4));
        chk("t1_w8", memw(8), 0);
        arst_ni = 1;
        tick();
        chk("t1_nodone", 32'({pl_done, pl_busy}), 0);
        tick();
        chk("t1_nodone2", 32'({pl_done, pl_busy}), 0);

        // 2: full preload of two words, then core read
        pl_start = 1; pl_base = 0; pl_len = 2;
        tick();
        pl_start = 0; pl_valid = 1; pl_data = 32'h05;
        tick();
        pl_data = 32'h0A;
        tick();
        pl_valid = 0;
        ref_write(0, 32'h05);
        ref_write(4, 32'h0A);
        chk("t2_done", pl_done, 1);
        chk("t2_busy", pl_busy, 0);
        tick();
        chk("t2_done_pulse", pl_done, 0);
        access(0, 0, 0, 0);
        chk("t2_rd_val", core_rdata, 32'h05);

        // 3: core write then read back
        access(0, 1, 8, 32'h0A);
        access(0, 0, 8, 0);
        chk("t3_rd_val", core_rdata, 32'h0000_000A);

        // 4: both ports requesting from reset alternate, core first
        arst_ni = 0; #1; arst_ni = 1;
        core_req = 1; core_we = 0; core_addr = 0;
        dbg_req = 1; dbg_we = 0; dbg_addr = 4;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t4_cgnt", core_gnt, 32'(k % 2 == 0));
            chk("t4_dgnt", dbg_gnt, 32'(k % 2 == 1));
            tick();
            chk("t4_cval", core_rvalid, 32'(k % 2 == 0));
            chk("t4_dval", dbg_rvalid, 32'(k % 2 == 1));
            if (k % 2 == 0) chk("t4_crd", core_rdata, refw(0));
            else            chk("t4_drd", dbg_rdata, refw(4));
        end
        core_req = 0; dbg_req = 0;

        // 5: out-of-range write, then a preload that runs off the end
        access(0, 1, 32'h75, 32'h1234_5678);
        pl_start = 1; pl_base = 32'h74; pl_len = 2;
        tick();
        pl_start = 0; pl_valid = 1; pl_data = 32'hDEAD_BEEF;
        #1;
        chk("t5_den", c_data_en, 1);
        chk("t5_iaddr", c_input_addr, 32'h74);
        ref_write(32'h74, 32'hDEAD_BEEF);
        tick();
        #1;
        chk("t5_no_oor_write", c_data_en, 0);
        tick();
        pl_valid = 0;
        chk("t5_err", err, 1);
        chk("t5_done", pl_done, 1);
        tick();
        chk("t5_idle", 32'({pl_done, pl_busy, err}), 0);
        chk("t5_w74", memw(32'h74), 32'hDEAD_BEEF);

        // 6a: zero-length preload with a core request in the start cycle
        pl_start = 1; pl_base = 0; pl_len = 0;
        core_req = 1; core_we = 0; core_addr = 4;
        #1;
        chk("t6_gnt_start", core_gnt, 1);
        tick();
        pl_start = 0; core_req = 0;
        chk("t6_rvalid", core_rvalid, 1);
        chk("t6_rdata", core_rdata, refw(4));
        chk("t6_busy", pl_busy, 1);
        chk("t6_den0", c_data_en, 0);
        tick();
        chk("t6_done0", pl_done, 1);
        tick();
        chk("t6_done0_pulse", pl_done, 0);

        // 6b: debug request held during a 4-word preload with pl_valid toggling
        pl_start = 1; pl_base = 32'h20; pl_len = 4;
        tick();
        pl_start = 0;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h20;
        words = 0; cyc = 0;
        while (words < 4 && cyc < 20) begin
            pl_valid = (cyc % 2 == 0);
            pl_data  = 32'h100 + 32'(words);
            #1;
            chk("t6_dgnt_low", dbg_gnt, 0);
            chk("t6_stall", c_data_en, 32'(pl_valid));
            chk("t6_ready", pl_ready, 1);
            if (pl_valid) begin
                ref_write(32'h20 + 32'(4 * words), pl_data);
                words++;
            end
            tick();
            cyc++;
        end
        chk("t6_words", 32'(words), 4);
        pl_valid = 0;
        #1;
        chk("t6_done", pl_done, 1);
        chk("t6_dgnt_done", dbg_gnt, 0);
        tick();
        chk("t6_dgnt_after", dbg_gnt, 1);
        tick();
        dbg_req = 0;
        chk("t6_drval", dbg_rvalid, 1);
        chk("t6_drdata", dbg_rdata, 32'h100);

        // Random core/debug traffic against the memory image
        arst_ni = 0; #1; arst_ni = 1;
        last_dbg = 1;
        pc = '{0, 0, 0, 0};
        pd = '{0, 0, 0, 0};
        for (int n = 0; n < 300; n++) begin
            if (!pc.vld && $urandom_range(0, 2) != 0)
                pc = '{1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 31) * 4), $urandom};
            if (!pd.vld && $urandom_range(0, 2) != 0)
                pd = '{1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 31) * 4), $urandom};
            core_req = pc.vld; core_we = pc.we; core_addr = pc.a; core_wd = pc.wd;
            dbg_req  = pd.vld; dbg_we  = pd.we; dbg_addr  = pd.a; dbg_wd  = pd.wd;
            #1;
            gc = pc.vld && (!pd.vld || last_dbg);
            gd = pd.vld && !gc;
            chk("rnd_cgnt", core_gnt, 32'(gc));
            chk("rnd_dgnt", dbg_gnt, 32'(gd));
            e_crd = (gc && !pc.we) ? refw(pc.a) : 32'h0;
            e_drd = (gd && !pd.we) ? refw(pd.a) : 32'h0;
            e_err = (gc && !inr(pc.a)) || (gd && !inr(pd.a));
            if (gc && pc.we && inr(pc.a)) ref_write(pc.a, pc.wd);
            if (gd && pd.we && inr(pd.a)) ref_write(pd.a, pd.wd);
            if (gc || gd) last_dbg = gd;
            tick();
            chk("rnd_cval", core_rvalid, 32'(gc));
            chk("rnd_dval", dbg_rvalid, 32'(gd));
            chk("rnd_err", err, 32'(e_err));
            if (gc) chk("rnd_crd", core_rdata, e_crd);
            if (gd) chk("rnd_drd", dbg_rdata, e_drd);
            if (gc) pc.vld = 0;
            if (gd) pd.vld = 0;
        end
        core_req = 0; dbg_req = 0;
        tick();

        diffs = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk("mem_image", 32'(diffs), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
